// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entries carry the fetch PC alongside the ROM word so decode sees both.
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_W     = 32;
  localparam int unsigned INST_W          = 32;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_addr_t INIT_ADDR_DEF = 32'h0000_0000;
  localparam inst_t      ZERO_WORD     = '0;
  localparam logic       CHIP_ENABLE   = 1'b1;
  localparam logic       CHIP_DISABLE  = 1'b0;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  typedef enum logic {
    FS_IDLE,
    FS_RUN
  } fetch_state_e;

  function automatic inst_addr_t word_align(input inst_addr_t addr);
    return addr & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handoff: valid/ready handshake carrying {pc, inst}.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic       id_valid_o;
  inst_addr_t id_pc_o;
  inst_t      id_inst_o;
  logic       id_ready_i;

  modport master (
    output id_valid_o,
    output id_pc_o,
    output id_inst_o,
    input  id_ready_i
  );

  modport slave (
    input  id_valid_o,
    input  id_pc_o,
    input  id_inst_o,
    output id_ready_i
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry {pc, inst} buffer between ROM capture and decode.
// Head reads as all-zero whenever the buffer is empty.
module inst_fifo
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign push_ok = push && ((count < 2'(FETCH_BUF_DEPTH)) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives ROM ce/pc, captures the returned word and
// buffers it for decode; branch redirects flush the buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_t INIT_ADDR = INIT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ce,
  output inst_addr_t        pc,
  input  inst_t             inst_i,
  input  logic              branch_flag_i,
  input  inst_addr_t        branch_target_i,
  inst_fetch_if.master      id
);

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t wr_entry;
  logic         pop;
  logic         fetch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ce comes up one edge after reset release and then stays on.
  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE: state_nxt = FS_RUN;
      FS_RUN:  state_nxt = FS_RUN;
      default: state_nxt = FS_IDLE;
    endcase
  end

  assign ce = (state == FS_RUN) ? CHIP_ENABLE : CHIP_DISABLE;

  assign pop   = id.id_valid_o & id.id_ready_i;
  assign fetch = (ce == CHIP_ENABLE)
               & ((count < 2'(FETCH_BUF_DEPTH)) | pop)
               & ~branch_flag_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= INIT_ADDR;
    end else if (branch_flag_i) begin
      pc <= word_align(branch_target_i);
    end else if (fetch) begin
      pc <= pc + 32'd4;
    end
  end

  assign wr_entry = '{pc: pc, inst: inst_i};

  inst_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fetch),
    .pop      (pop),
    .flush    (branch_flag_i),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  assign id.id_valid_o = (count != 2'd0);
  assign id.id_pc_o    = head.pc;
  assign id.id_inst_o  = head.inst;

endmodule
